// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, level plus press/release/long pulses.
// Optional build macro AUTO_REPEAT_EN: btn_press auto-repeats every REPEAT_CNT cycles after a long hold.
module button_debounce #(
    parameter int DEBOUNCE_CNT = 500000,
    parameter int LONG_CNT     = 25000000,
    parameter int REPEAT_CNT   = 5000000
) (
    input  logic clk_g,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam int HW = $clog2(LONG_CNT);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CNT - 1);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CNT - 1);
    localparam logic [RW-1:0] REP_ONE = RW'(1);
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, btn_s;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_flag_q, long_flag_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
`ifdef AUTO_REPEAT_EN
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

    // Synchroniser chain; btn_s is the only view of the button used below.
    always_ff @(posedge clk_g or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            btn_s   <= sync1_q;
        end
    end

    // Next-state and pulse decode for the debounce FSM.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (btn_s) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_flag_d = 1'b0;
`ifdef AUTO_REPEAT_EN
                    rep_cnt_d   = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else begin
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                    if ((hold_cnt_q == HOLD_MAX) && !long_flag_q) begin
                        long_d      = 1'b1;
                        long_flag_d = 1'b1;
`ifdef AUTO_REPEAT_EN
                        press_d     = 1'b1;
                        rep_cnt_d   = '0;
                    end else if (long_flag_q) begin
                        // Repeat period restarts on every pulse, including the one paired with btn_long.
                        if (rep_cnt_q == REP_MAX) begin
                            press_d   = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
`endif
                    end else begin
                        long_flag_d = long_flag_q;
                    end
                end
            end
            RELEASE_WAIT: begin
                // hold_cnt and long_flag are intentionally untouched so a bounce cannot re-arm btn_long.
                if (btn_s) begin
                    state_d   = HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_g or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
`ifdef AUTO_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed test-plan segments plus random bounce traffic
// checked every cycle against a run-length behavioural model.
module tb_button_debounce;
    localparam int D = 8;
    localparam int L = 32;
    localparam int R = 8;

    logic clk_g = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_level, btn_press, btn_release, btn_long;

    int checks   = 0;
    int failures = 0;

    button_debounce #(.DEBOUNCE_CNT(D), .LONG_CNT(L), .REPEAT_CNT(R)) dut (
        .clk_g(clk_g), .rst(rst), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk_g = ~clk_g;

    // Model: the input seen by the debouncer is btn_raw two samples late; the accepted level flips
    // once D+1 consecutive samples disagree with it; a hold cycle is two consecutive high samples.
    bit m_s1, m_s2, m_prev, m_level, m_longed;
    int m_run, m_cnt, m_rep;
    bit e_press, e_rel, e_long;

    int seg_cyc, seg_press, seg_rel, seg_long, first_press_at, long_at, rel_at;

    function automatic void model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0; m_level = 1'b0; m_longed = 1'b0;
        m_run = 0; m_cnt = 0; m_rep = 0;
    endfunction

    function automatic void model_edge(input bit raw);
        bit b;
        b = m_s2; m_s2 = m_s1; m_s1 = raw;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        if (!m_level) begin
            m_run = b ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_level = 1'b1; e_press = 1'b1; m_run = 0;
                m_cnt = 0; m_longed = 1'b0; m_rep = 0;
            end
        end else begin
            if (m_prev && b) begin
                m_cnt++;
                if (m_cnt == L && !m_longed) begin
                    e_long = 1'b1; m_longed = 1'b1; m_rep = 0;
`ifdef AUTO_REPEAT_EN
                    e_press = 1'b1;
`endif
                end else if (m_longed) begin
                    m_rep++;
`ifdef AUTO_REPEAT_EN
                    if (m_rep == R) begin
                        e_press = 1'b1; m_rep = 0;
                    end
`endif
                end
            end
            m_run = !b ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_level = 1'b0; e_rel = 1'b1; m_run = 0;
            end
        end
        m_prev = b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic seg_start();
        seg_cyc = 0; seg_press = 0; seg_rel = 0; seg_long = 0;
        first_press_at = -1; long_at = -1; rel_at = -1;
    endtask

    task automatic step(input logic v);
        btn_raw = v;
        @(posedge clk_g);
        model_edge(v);
        #1;
        chk("cycle{level,press,release,long}",
            {28'd0, btn_level, btn_press, btn_release, btn_long},
            {28'd0, m_level, e_press, e_rel, e_long});
        if (btn_press === 1'b1) begin
            seg_press++;
            if (first_press_at < 0) first_press_at = seg_cyc;
        end
        if (btn_long === 1'b1) begin
            seg_long++; long_at = seg_cyc;
        end
        if (btn_release === 1'b1) begin
            seg_rel++; rel_at = seg_cyc;
        end
        seg_cyc++;
    endtask

    task automatic run(input logic v, input int n);
        repeat (n) step(v);
    endtask

    initial begin
        logic v;
        int len;
        rst = 1'b0;
        btn_raw = 1'b0;
        repeat (3) @(posedge clk_g);
        #1;
        chk("reset_outputs", {28'd0, btn_level, btn_press, btn_release, btn_long}, 32'd0);
        @(negedge clk_g);
        rst = 1'b1;
        model_reset();
        seg_start();
        run(1'b0, 5);

        // Clean press and release.
        seg_start();
        run(1'b1, 20);
        chk("clean_press_edge", first_press_at, 32'd10);
        chk("clean_press_count", seg_press, 32'd1);
        chk("clean_level_held", {31'd0, btn_level}, 32'd1);
        run(1'b0, 20);
        chk("clean_release_edge", rel_at, 32'd30);
        chk("clean_release_count", seg_rel, 32'd1);
        chk("clean_no_long", seg_long, 32'd0);

        // Glitch shorter than the debounce window.
        seg_start();
        run(1'b1, 5);
        run(1'b0, 20);
        chk("glitch_no_press", seg_press, 32'd0);
        chk("glitch_level_low", {31'd0, btn_level}, 32'd0);

        // Bouncy release.
        seg_start();
        run(1'b1, 20);
        run(1'b0, 3); run(1'b1, 3); run(1'b0, 3); run(1'b1, 3);
        run(1'b0, 20);
        chk("bounce_release_edge", rel_at, 32'd42);
        chk("bounce_release_count", seg_rel, 32'd1);
        chk("bounce_press_count", seg_press, 32'd1);

        // Long hold.
        seg_start();
        run(1'b1, 60);
        run(1'b0, 20);
        chk("long_count", seg_long, 32'd1);
        chk("long_delay", long_at - first_press_at, 32'd32);
`ifdef AUTO_REPEAT_EN
        chk("long_press_count", seg_press, 32'd4);
`else
        chk("long_press_count", seg_press, 32'd1);
`endif

        // Asynchronous reset while held, button still down afterwards.
        seg_start();
        run(1'b1, 20);
        rst = 1'b0;
        #1;
        chk("reset_async_outputs", {28'd0, btn_level, btn_press, btn_release, btn_long}, 32'd0);
        model_reset();
        @(posedge clk_g);
        @(posedge clk_g);
        @(negedge clk_g);
        rst = 1'b1;
        seg_start();
        run(1'b1, 15);
        chk("reset_repress_edge", first_press_at, 32'd10);
        run(1'b0, 20);

        // Saturation: hold for twice the long threshold.
        seg_start();
        run(1'b1, 2 * L);
        chk("sat_long_count", seg_long, 32'd1);
        chk("sat_long_delay", long_at - first_press_at, 32'd32);
        chk("sat_level_high", {31'd0, btn_level}, 32'd1);
        run(1'b0, 20);

        // Random bounce traffic with occasional long holds.
        v = 1'b0;
        repeat (150) begin
            v = ~v;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(35, 80))
                                              : int'($urandom_range(1, 16));
            run(v, len);
        end
        run(1'b0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
